// File: rtl/module_teclado.sv
// 4x4 matrix keypad scanner: column scan, row synchronizer, press/release debounce.
// Emits one key_pulse per debounced press and holds key_code until the next accepted key.
//   state    | meaning
//   SCAN     | rotate low column, sample rows at end of each dwell
//   DEBOUNCE | column frozen, count consecutive low cycles of latched row
//   PRESS    | one cycle: key_pulse, key_code and key_held asserted
//   HOLD     | wait for latched row to go high, other keys ignored
//   RELEASE  | count consecutive high cycles before scanning resumes
module module_teclado #(
  parameter int SCAN_DIV        = 27000,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_pulse,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_DIV) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {SCAN, DEBOUNCE, PRESS, HOLD, RELEASE} state_t;

  state_t        r_state;
  logic [3:0]    r_row_meta;
  logic [3:0]    r_row_sync;
  logic [1:0]    r_col_idx;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_col_n;
  logic [SW-1:0] r_scan_cnt;
  logic [DW-1:0] r_db_cnt;
  logic [3:0]    r_key_code;
  logic          r_key_pulse;
  logic          r_key_held;

  logic          w_row_any;
  logic [1:0]    w_row_first;
  logic          w_latched_low;
  logic [1:0]    w_col_next;
  logic [3:0]    w_col_next_n;
  logic [3:0]    w_code;

  assign w_row_any     = ~&r_row_sync;
  assign w_latched_low = ~r_row_sync[r_row_idx];
  assign w_col_next    = r_col_idx + 2'd1;
  assign w_col_next_n  = ~(4'b0001 << w_col_next);

  // Scan downward so the lowest-index low row wins.
  always_comb begin
    w_row_first = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_row_sync[i]) w_row_first = 2'(i);
    end
  end

  always_comb begin
    w_code = 4'd0;
    case ({r_row_idx, r_col_idx})
      4'd0:  w_code = 4'd1;
      4'd1:  w_code = 4'd2;
      4'd2:  w_code = 4'd3;
      4'd3:  w_code = 4'd10;
      4'd4:  w_code = 4'd4;
      4'd5:  w_code = 4'd5;
      4'd6:  w_code = 4'd6;
      4'd7:  w_code = 4'd11;
      4'd8:  w_code = 4'd7;
      4'd9:  w_code = 4'd8;
      4'd10: w_code = 4'd9;
      4'd11: w_code = 4'd12;
      4'd12: w_code = 4'd14;
      4'd13: w_code = 4'd0;
      4'd14: w_code = 4'd15;
      4'd15: w_code = 4'd13;
      default: w_code = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCAN;
      r_row_meta  <= 4'b1111;
      r_row_sync  <= 4'b1111;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_col_n     <= 4'b1110;
      r_scan_cnt  <= '0;
      r_db_cnt    <= '0;
      r_key_code  <= 4'd0;
      r_key_pulse <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_row_meta  <= row_n;
      r_row_sync  <= r_row_meta;
      r_key_pulse <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            if (w_row_any) begin
              r_row_idx <= w_row_first;
              r_db_cnt  <= '0;
              r_state   <= DEBOUNCE;
            end else begin
              r_col_idx <= w_col_next;
              r_col_n   <= w_col_next_n;
            end
          end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (w_latched_low) begin
            if (r_db_cnt == DB_LAST) begin
              r_db_cnt    <= '0;
              r_key_pulse <= 1'b1;
              r_key_code  <= w_code;
              r_key_held  <= 1'b1;
              r_state     <= PRESS;
            end else begin
              r_db_cnt <= r_db_cnt + DW'(1);
            end
          end else begin
            r_db_cnt  <= '0;
            r_col_idx <= w_col_next;
            r_col_n   <= w_col_next_n;
            r_state   <= SCAN;
          end
        end
        PRESS: r_state <= HOLD;
        HOLD: begin
          if (!w_latched_low) begin
            r_db_cnt <= '0;
            r_state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (w_latched_low) begin
            r_state <= HOLD;
          end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt   <= '0;
            r_key_held <= 1'b0;
            r_col_idx  <= w_col_next;
            r_col_n    <= w_col_next_n;
            r_state    <= SCAN;
          end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign col_n     = r_col_n;
  assign key_code  = r_key_code;
  assign key_pulse = r_key_pulse;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_module_teclado.sv
// Keypad scanner bench: switch-matrix model driven by col_n, expected codes queued
// from the key map and checked by a monitor whenever key_pulse fires.
module tb_module_teclado;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_pulse;
  logic       key_held;

  logic [15:0] pressed = '0;
  int keymap [4][4];
  int exp_q [$];
  int checks = 0;
  int errors = 0;
  int acc = 0;
  int entry = 0;
  bit mon_en = 1'b0;
  bit prev_pulse = 1'b0;

  module_teclado #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_pulse(key_pulse), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A row reads low when any pressed switch on it sits on a driven-low column.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones(~col_n) != 1) begin
        errors++;
        $display("FAIL col_onehot: col_n=%b, need exactly one low bit", col_n);
      end
      if (key_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: key_code=%0d, no pulse expected", key_code);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(key_code) != e) begin
            errors++;
            $display("FAIL key_code: got %0d, expected %0d", key_code, e);
          end
        end
        checks++;
        if (!key_held || prev_pulse) begin
          errors++;
          $display("FAIL pulse_shape: key_held=%0b prev_pulse=%0b, need 1 and 0", key_held, prev_pulse);
        end
        if (key_code == 4'd12) begin acc = 0; entry = 0; end
        else if (key_code == 4'd10 || key_code == 4'd11) begin acc += entry; entry = 0; end
        else if (key_code < 4'd10) entry = entry * 10 + int'(key_code);
      end
    end
    prev_pulse = key_pulse;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic unpress(input int r, input int c);
    pressed[r*4+c] = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(1); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d pulses still outstanding after %0d cycles, expected 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic key_stroke(input string name, input int r, input int c, input int hold);
    press(r, c);
    exp_q.push_back(keymap[r][c]);
    wait_drain(name, 200);
    tick(hold);
    unpress(r, c);
    tick(25);
  endtask

  initial begin
    logic [3:0] col_seen;
    bit moved;
    keymap = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    tick(3);
    mon_en = 1'b1;
    chk("rst_col_n", int'(col_n), 14);
    chk("rst_key_code", int'(key_code), 0);
    chk("rst_key_pulse", int'(key_pulse), 0);
    chk("rst_key_held", int'(key_held), 0);
    rst = 1'b0;

    // Clean press of 5 for 60 cycles, then release debounce timing.
    press(1, 1);
    exp_q.push_back(keymap[1][1]);
    tick(60);
    wait_drain("press5", 0);
    chk("press5_held", int'(key_held), 1);
    unpress(1, 1);
    tick(8);
    chk("release5_held_early", int'(key_held), 1);
    tick(6);
    chk("release5_held_late", int'(key_held), 0);
    chk("release5_code_kept", int'(key_code), 5);
    tick(20);

    // Bouncing contact every 3 cycles, then settles low.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) press(2, 1); else unpress(2, 1);
      tick(3);
    end
    key_stroke("bounce8", 2, 1, 20);

    // Isolated 5-cycle glitch: no pulse, scanning resumes.
    press(0, 2);
    tick(5);
    unpress(0, 2);
    col_seen = col_n;
    moved = 1'b0;
    for (int i = 0; i < 12 && !moved; i++) begin
      tick(1);
      if (col_n != col_seen) moved = 1'b1;
    end
    chk("glitch_scan_resumes", int'(moved), 1);
    tick(30);

    // CLEAR, 1, 2, ADD into the downstream adder.
    key_stroke("seq_clear", 2, 3, 10);
    key_stroke("seq_1", 0, 0, 10);
    key_stroke("seq_2", 0, 1, 10);
    key_stroke("seq_add", 0, 3, 10);
    chk("adder_result", acc, 12);

    // 1 and 4 together, then 9 pressed while 1 held.
    press(0, 0);
    press(1, 0);
    exp_q.push_back(keymap[0][0]);
    wait_drain("dual_1_4", 200);
    tick(10);
    unpress(1, 0);
    press(2, 2);
    tick(60);
    unpress(0, 0);
    exp_q.push_back(keymap[2][2]);
    wait_drain("nine_after_one", 200);
    tick(10);
    unpress(2, 2);
    tick(25);

    key_stroke("key_D", 3, 3, 15);
    key_stroke("key_star", 3, 0, 15);
    key_stroke("key_hash", 3, 2, 15);

    for (int i = 0; i < 12; i++) begin
      int r, c;
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      key_stroke("random_key", r, c, int'($urandom_range(5, 50)));
    end

    // Reset in the middle of a debounce.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    press(0, 0);
    tick(8);
    rst = 1'b1;
    tick(1);
    chk("rstdb_col_n", int'(col_n), 14);
    chk("rstdb_key_code", int'(key_code), 0);
    chk("rstdb_key_held", int'(key_held), 0);
    chk("rstdb_key_pulse", int'(key_pulse), 0);
    unpress(0, 0);
    tick(1);
    rst = 1'b0;
    tick(40);

    chk("leftover_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
